// File: rtl/qam_dac_out_if.sv
// Sample-stream and DAC-side signal bundle for qam_dac_out.
// The master drives the modulated stream and the error clear; the slave produces DAC words and status.
interface qam_dac_out_if #(
   parameter int QAM_WIDTH = 12,
   parameter int DAC_WIDTH = 10
);
   logic                        qam_valid;
   logic signed [QAM_WIDTH-1:0] qam_data;
   logic                        clr_err;
   logic [DAC_WIDTH-1:0]        dac_data;
   logic                        dac_wr;
   logic                        dac_active;
   logic                        underflow;
   logic                        overflow;

   modport master (
      output qam_valid, qam_data, clr_err,
      input  dac_data, dac_wr, dac_active, underflow, overflow
   );

   modport slave (
      input  qam_valid, qam_data, clr_err,
      output dac_data, dac_wr, dac_active, underflow, overflow
   );
endinterface

// File: rtl/qam_dac_out.sv
// QAM output stage: round/saturate to offset binary, buffer in a FIFO, pace out one word per DIV clocks.
// Optional test ramp generator enabled by defining QAM_DAC_RAMP_EN (adds port ramp_mode).
module qam_dac_out #(
   parameter int QAM_WIDTH   = 12,
   parameter int DAC_WIDTH   = 10,
   parameter int FIFO_DEPTH  = 16,
   parameter int DIV         = 4,
   parameter int PRIME_LEVEL = 4
) (
   input  logic axi_clk,
   input  logic axi_rst,
`ifdef QAM_DAC_RAMP_EN
   input  logic ramp_mode,
`endif
   qam_dac_out_if.slave bus
);
   localparam int SH = QAM_WIDTH - DAC_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DIV);
   localparam logic [QAM_WIDTH:0]        RND     = (QAM_WIDTH+1)'(1) << (SH - 1);
   localparam logic signed [DAC_WIDTH:0] SAT_HI  = {2'b00, {(DAC_WIDTH-1){1'b1}}};
   localparam logic signed [DAC_WIDTH:0] SAT_LO  = ~SAT_HI;
   localparam logic [DAC_WIDTH-1:0]      MID     = {1'b1, {(DAC_WIDTH-1){1'b0}}};
   localparam logic [AW:0]               FULL_LV = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]               PRIME_LV = (AW+1)'(PRIME_LEVEL);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   // Round half up, then drop the low SH bits (slice keeps the sign: arithmetic shift).
   function automatic logic signed [DAC_WIDTH:0] round_shift(input logic signed [QAM_WIDTH-1:0] x);
      logic signed [QAM_WIDTH:0] s;
      s = {x[QAM_WIDTH-1], x} + RND;
      return s[QAM_WIDTH:SH];
   endfunction

   function automatic logic [DAC_WIDTH-1:0] sat_offset(input logic signed [DAC_WIDTH:0] v);
      logic [DAC_WIDTH-1:0] r;
      if (v > SAT_HI)      r = SAT_HI[DAC_WIDTH-1:0];
      else if (v < SAT_LO) r = SAT_LO[DAC_WIDTH-1:0];
      else                 r = v[DAC_WIDTH-1:0];
      return {~r[DAC_WIDTH-1], r[DAC_WIDTH-2:0]};
   endfunction

   logic                 vld_p1;
   logic [DAC_WIDTH-1:0] data_p1;
   logic [CW-1:0]        div_cnt;
   logic                 tick, seen, live;
   logic [DAC_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          level;
   logic                 full, push, pop;
   state_t               state_q, state_n;
   logic                 out_load, out_mid, uf_set, ovf_set, ramp_on;
   logic [DAC_WIDTH-1:0] dac_q;
   logic                 wr_q, uf_q, ovf_q;

   // Stage p0 -> p1: format the incoming sample.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) vld_p1 <= 1'b0;
      else         vld_p1 <= bus.qam_valid;
   end

   always_ff @(posedge axi_clk) begin
      data_p1 <= sat_offset(round_shift(bus.qam_data));
   end

   assign tick = (div_cnt == CW'(DIV - 1));
   assign live = seen | bus.qam_valid;

   // seen collects qam_valid over the divider period ending at the next tick.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         div_cnt <= '0;
         seen    <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         seen    <= tick ? 1'b0 : (seen | bus.qam_valid);
      end
   end

   // Stage p1 -> FIFO.
   assign full    = (level == FULL_LV);
   assign push    = vld_p1 && (!full || pop);
   assign ovf_set = vld_p1 && full && !pop;

   always_ff @(posedge axi_clk) begin
      if (push) mem[wr_ptr] <= data_p1;
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

`ifdef QAM_DAC_RAMP_EN
   logic [DAC_WIDTH-1:0] ramp_cnt;
   assign ramp_on = ramp_mode;

   always_ff @(posedge axi_clk) begin
      if (axi_rst || !ramp_mode) ramp_cnt <= '0;
      else if (tick)             ramp_cnt <= ramp_cnt + 1'b1;
   end
`else
   assign ramp_on = 1'b0;
`endif

   always_ff @(posedge axi_clk) begin
      if (axi_rst) state_q <= IDLE;
      else         state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      pop      = 1'b0;
      out_load = 1'b0;
      out_mid  = 1'b0;
      uf_set   = 1'b0;
      if (ramp_on) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               out_mid = tick;
               if (vld_p1 && !full) state_n = PRIME;
            end
            PRIME: begin
               if (tick) begin
                  if (level >= PRIME_LV) begin
                     pop      = 1'b1;
                     out_load = 1'b1;
                     state_n  = RUN;
                  end else begin
                     out_mid = 1'b1;
                  end
               end
            end
            RUN: begin
               if (tick) begin
                  if (level != '0) begin
                     pop      = 1'b1;
                     out_load = 1'b1;
                  end else begin
                     out_mid = 1'b1;
                     uf_set  = live;
                     state_n = IDLE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Output register stage: DAC word, strobe and sticky flags.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         dac_q <= MID;
         wr_q  <= 1'b0;
         uf_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (out_load)     dac_q <= mem[rd_ptr];
         else if (out_mid) dac_q <= MID;
`ifdef QAM_DAC_RAMP_EN
         else if (ramp_on && tick) dac_q <= ramp_cnt;
`endif
         wr_q  <= tick;
         uf_q  <= uf_set  | (uf_q  & ~bus.clr_err);
         ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
      end
   end

   assign bus.dac_data   = dac_q;
   assign bus.dac_wr     = wr_q;
   assign bus.dac_active = (state_q == RUN);
   assign bus.underflow  = uf_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_qam_dac_out.sv
// Bench for qam_dac_out: directed phases plus random traffic, compared every cycle to a queue-based model.
module tb_qam_dac_out;
   localparam int QW = 12, DW = 10, DEPTH = 16, DIV = 4, PL = 4;
   localparam int MID = 1 << (DW - 1);
   localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

   logic clk = 1'b0;
   logic rst;
   logic ramp_mode;
   always #5 clk = ~clk;

   qam_dac_out_if #(.QAM_WIDTH(QW), .DAC_WIDTH(DW)) bus ();

   qam_dac_out #(.QAM_WIDTH(QW), .DAC_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV(DIV), .PRIME_LEVEL(PL)) dut (
      .axi_clk(clk),
      .axi_rst(rst),
`ifdef QAM_DAC_RAMP_EN
      .ramp_mode(ramp_mode),
`endif
      .bus(bus)
   );

   int n_cmp = 0, n_bad = 0;

   int m_cnt, m_mode, m_dac, m_ramp, m_pend_w;
   bit m_win, m_pend_v, m_wr, m_uf, m_ovf;
   int q[$];

   // Nearest-integer scaling with floor, clamp to DAC range, then shift to offset binary.
   function automatic int fmt(input int d);
      int div_f, t, f;
      div_f = 1 << (QW - DW);
      t = d + div_f / 2;
      f = t / div_f;
      if (t < 0 && (t % div_f) != 0) f = f - 1;
      if (f > MID - 1) f = MID - 1;
      if (f < -MID)    f = -MID;
      return f + MID;
   endfunction

   task automatic model_step(input bit r, input bit v, input int d, input bit c, input bit rm);
      bit tick, live, uf_set, ovf_set;
      int nxt;
      if (r) begin
         m_cnt = 0; m_mode = M_IDLE; m_win = 0; m_pend_v = 0; q.delete();
         m_dac = MID; m_wr = 0; m_uf = 0; m_ovf = 0; m_ramp = 0;
      end else begin
         tick = (m_cnt == DIV - 1);
         live = m_win || v;
         uf_set = 0; ovf_set = 0;
         nxt = m_mode;
         m_wr = tick;
         if (rm) begin
            if (tick) begin
               m_dac = m_ramp;
               m_ramp = (m_ramp + 1) % (1 << DW);
            end
            nxt = M_IDLE;
         end else begin
            m_ramp = 0;
            if (m_mode == M_IDLE) begin
               if (tick) m_dac = MID;
               if (m_pend_v && q.size() < DEPTH) nxt = M_PRIME;
            end else if (m_mode == M_PRIME) begin
               if (tick) begin
                  if (q.size() >= PL) begin m_dac = q.pop_front(); nxt = M_RUN; end
                  else m_dac = MID;
               end
            end else if (tick) begin
               if (q.size() > 0) m_dac = q.pop_front();
               else begin m_dac = MID; nxt = M_IDLE; uf_set = live; end
            end
         end
         if (m_pend_v) begin
            if (q.size() < DEPTH) q.push_back(m_pend_w);
            else ovf_set = 1;
         end
         m_uf  = uf_set  | (m_uf  & !c);
         m_ovf = ovf_set | (m_ovf & !c);
         m_win = tick ? 1'b0 : (m_win | v);
         m_pend_v = v;
         m_pend_w = fmt(d);
         m_cnt = tick ? 0 : m_cnt + 1;
         m_mode = nxt;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit v, input int d, input bit c, input bit rm);
      int dv;
      dv = d;
      rst = r;
      bus.qam_valid = v;
      bus.qam_data = dv[QW-1:0];
      bus.clr_err = c;
      ramp_mode = rm;
      @(posedge clk);
      model_step(r, v, d, c, rm);
      #1;
      chk("dac_data",   32'(bus.dac_data),   m_dac);
      chk("dac_wr",     32'(bus.dac_wr),     32'(m_wr));
      chk("dac_active", 32'(bus.dac_active), 32'(m_mode == M_RUN));
      chk("underflow",  32'(bus.underflow),  32'(m_uf));
      chk("overflow",   32'(bus.overflow),   32'(m_ovf));
   endtask

   function automatic int rnd_data();
      return int'($urandom_range(0, (1 << QW) - 1)) - (1 << (QW - 1));
   endfunction

   int burst[5] = '{0, 5, 6, 2047, -2048};
   int guard;

   initial begin
      rst = 1'b1; ramp_mode = 1'b0;
      bus.qam_valid = 1'b0; bus.qam_data = '0; bus.clr_err = 1'b0;

      // Reset, then idle: midscale words on a steady strobe.
      repeat (3) step(1, 0, 0, 0, 0);
      chk("reset_dac_mid", 32'(bus.dac_data), MID);
      repeat (20) step(0, 0, 0, 0, 0);

      // Directed burst including both saturation extremes.
      for (int i = 0; i < 5; i++) begin
         step(0, 1, burst[i], 0, 0);
         repeat (3) step(0, 0, 0, 0, 0);
      end
      repeat (40) step(0, 0, 0, 0, 0);
      chk("burst_end_no_underflow", 32'(bus.underflow), 0);

      // Continuous input: FIFO fills and overflows, then drains.
      repeat (40) step(0, 1, rnd_data(), 0, 0);
      chk("overflow_seen", 32'(bus.overflow), 1);
      repeat (100) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);

      // Steady feed then a slower feed so the FIFO runs dry mid-burst; random clr_err.
      repeat (8) begin step(0, 1, rnd_data(), 0, 0); repeat (3) step(0, 0, 0, 0, 0); end
      repeat (20) begin
         step(0, 1, rnd_data(), $urandom_range(0, 3) == 0, 0);
         repeat (5) step(0, 0, 0, $urandom_range(0, 3) == 0, 0);
      end
      repeat (40) step(0, 0, 0, 0, 0);

      // Reset while running with entries queued.
      repeat (12) step(0, 1, rnd_data(), 0, 0);
      guard = 0;
      while (!(bus.dac_active && q.size() <= 6) && guard < 200) begin
         step(0, 0, 0, 0, 0);
         guard++;
      end
      chk("run_before_reset", 32'(bus.dac_active), 1);
      step(1, 0, 0, 0, 0);
      chk("after_reset_mid", 32'(bus.dac_data), MID);
      repeat (30) step(0, 0, 0, 0, 0);

      // Random traffic with occasional clears and resets.
      repeat (3000) step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                         rnd_data(), $urandom_range(0, 29) == 0, 0);
      repeat (3000) step(0, $urandom_range(0, 4) == 0, rnd_data(), $urandom_range(0, 49) == 0, 0);

`ifdef QAM_DAC_RAMP_EN
      // Ramp generator over a full wrap, with some input traffic still arriving.
      repeat (1030 * DIV) step(0, $urandom_range(0, 9) == 0, rnd_data(), 0, 1);
      repeat (200) step(0, $urandom_range(0, 2) == 0, rnd_data(), 0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
